bt_pipe_out_feeder: RTL

- Single-clock buffering stage that feeds the block-throttled output pipe endpoint.
- Accepts 32-bit words from the imager datapath and stores them in an internal FIFO.
- Asserts ep_ready only when a full block of BLOCK_WORDS words is buffered.
- Supplies one word per host read, with one-cycle read latency, and tracks block progress and error conditions.

---
 rtl/bt_feed_pkg.sv | 12 +
 rtl/sync_fifo.sv | 56 +++++
 rtl/bt_pipe_out_feeder.sv | 100 ++++++++++
 3 files changed

// File: rtl/bt_feed_pkg.sv
// Shared constants and FSM encoding for the block-throttled pipe-out feeder.
package bt_feed_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_XFER  = 2'd2
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock RAM FIFO with registered read data, occupancy and full flag.
module sync_fifo #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full
);

    localparam int unsigned DEPTH = 32'd1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx, level_nx;
    logic             push, pop;

    // Pointers carry an extra wrap bit so full and empty differ.
    always_comb begin
        push      = wr_en && !full;
        pop       = rd_en && (level != '0);
        wr_ptr_nx = wr_ptr + PW'(push);
        rd_ptr_nx = rd_ptr + PW'(pop);
        level_nx  = wr_ptr_nx - rd_ptr_nx;
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            full    <= 1'b0;
            rd_data <= '0;
        end else begin
            wr_ptr <= wr_ptr_nx;
            rd_ptr <= rd_ptr_nx;
            level  <= level_nx;
            full   <= (level_nx == PW'(DEPTH));
            if (pop) begin
                rd_data <= mem[rd_ptr[DEPTH_LOG2-1:0]];
            end
        end
    end

endmodule

// File: rtl/bt_pipe_out_feeder.sv
// Buffers imager words and releases them to the host pipe one full block at a time.
module bt_pipe_out_feeder
    import bt_feed_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned BLOCK_WORDS = 256
) (
    input  logic                  okClk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_W-1:0]     wr_data,
    output logic                  wr_full,
    input  logic                  ep_read,
    input  logic                  ep_blockstrobe,
    output logic [DATA_W-1:0]     ep_datain,
    output logic                  ep_ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  proto_err
);

    localparam int unsigned LW = DEPTH_LOG2 + 1;
    localparam int unsigned RW = $clog2(BLOCK_WORDS) + 1;

    state_t        state;
    logic [RW-1:0] remaining;

    sync_fifo #(
        .WIDTH      (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (okClk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (ep_read),
        .rd_data (ep_datain),
        .level   (level),
        .full    (wr_full)
    );

    always_ff @(posedge okClk) begin
        if (rst) begin
            state     <= ST_IDLE;
            remaining <= '0;
            ep_ready  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (wr_en && wr_full) overflow <= 1'b1;
            if (ep_read && (level == '0)) underflow <= 1'b1;
            // Host may only read while a block transfer is open.
            if (ep_read && (state != ST_XFER)) proto_err <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (ep_blockstrobe) begin
                        proto_err <= 1'b1;
                        state     <= ST_XFER;
                        remaining <= RW'(BLOCK_WORDS);
                        ep_ready  <= 1'b0;
                    end else if (level >= LW'(BLOCK_WORDS)) begin
                        state    <= ST_ARMED;
                        ep_ready <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (ep_blockstrobe) begin
                        state     <= ST_XFER;
                        remaining <= RW'(BLOCK_WORDS);
                        ep_ready  <= 1'b0;
                    end else begin
                        ep_ready <= 1'b1;
                    end
                end
                ST_XFER: begin
                    ep_ready <= 1'b0;
                    if (ep_blockstrobe) begin
                        proto_err <= 1'b1;
                        remaining <= RW'(BLOCK_WORDS);
                    end else if (ep_read) begin
                        if (remaining == RW'(1)) begin
                            state     <= ST_IDLE;
                            remaining <= '0;
                        end else begin
                            remaining <= remaining - RW'(1);
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    ep_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
